// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling over raster-ordered conv planes.
// One output per 2x2 window, registered one cycle after its last sample; o_ready = !o_valid || i_ready.
module relu_maxpool_stream #(
   parameter int SUM_BW    = 16,
   parameter int DATA_SIZE = 28,
   parameter int CH_NUM    = 6
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic signed [SUM_BW-1:0] i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [SUM_BW-1:0] o_data,
   output logic                     o_last,
   output logic                     o_done
);
   localparam int PW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
   localparam int CW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int LB = DATA_SIZE / 2;
   localparam int AW = (LB > 1) ? $clog2(LB) : 1;
   localparam logic [PW-1:0] POS_MAX = PW'(DATA_SIZE - 1);
   localparam logic [CW-1:0] CH_MAX  = CW'(CH_NUM - 1);

   logic [PW-1:0]            col;
   logic [PW-1:0]            row;
   logic [CW-1:0]            ch;
   logic signed [SUM_BW-1:0] h;
   logic signed [SUM_BW-1:0] relu;
   logic signed [SUM_BW-1:0] pair;
   logic signed [SUM_BW-1:0] lb_rd;
   logic signed [SUM_BW-1:0] pooled;
   logic signed [SUM_BW-1:0] lbuf [LB];
   logic [AW-1:0]            lidx;
   logic                     accept;
   logic                     emit;
   logic                     out_hs;
   logic                     plane_end;
   logic                     frame_end;

   assign o_ready   = !o_valid || i_ready;
   assign accept    = i_valid && o_ready;
   assign out_hs    = o_valid && i_ready;
   assign emit      = accept && row[0] && col[0];
   assign plane_end = (row == POS_MAX) && (col == POS_MAX);

   // Post-ReLU values are non-negative, so all max compares stay in range without widening.
   assign relu   = i_data[SUM_BW-1] ? '0 : i_data;
   assign lidx   = AW'(col >> 1);
   assign pair   = (relu > h) ? relu : h;
   assign lb_rd  = lbuf[lidx];
   assign pooled = (pair > lb_rd) ? pair : lb_rd;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         col <= '0;
         row <= '0;
         ch  <= '0;
         h   <= '0;
      end else if (accept) begin
         if (!col[0]) h <= relu;
         if (col == POS_MAX) begin
            col <= '0;
            if (row == POS_MAX) begin
               row <= '0;
               ch  <= (ch == CH_MAX) ? '0 : ch + 1'b1;
            end else begin
               row <= row + 1'b1;
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Line buffer is always written on an even row before the odd row reads it, so no reset.
   always_ff @(posedge ACLK) begin
      if (accept && !row[0] && col[0]) lbuf[lidx] <= pair;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_last    <= 1'b0;
         o_done    <= 1'b0;
         frame_end <= 1'b0;
      end else begin
         o_done <= out_hs && frame_end;
         if (emit) begin
            o_valid   <= 1'b1;
            o_data    <= pooled;
            o_last    <= plane_end;
            frame_end <= plane_end && (ch == CH_MAX);
         end else if (out_hs) begin
            o_valid <= 1'b0;
         end
      end
   end
endmodule
